// File: rtl/qenc_pkg.sv
// Shared types, defaults and the counter step function for the
// quadrature encoder bank.
package qenc_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_e;

  localparam int DEB_CYCLES_DEF = 50000;
  localparam int ACCEL_WIN_DEF  = 2_500_000;
  localparam int ACCEL_STEP_DEF = 2;

  // Next counter value for one detent of `step` counts.
  // wrap=1: modulo max_val+1; wrap=0: clamp to [0, max_val].
  function automatic int unsigned next_val(
    input int unsigned cur,
    input dir_e        dir,
    input int unsigned step,
    input int unsigned max_val,
    input bit          wrap
  );
    int unsigned m;
    int unsigned s;
    m = max_val + 1;
    s = step % m;
    next_val = cur;
    if (wrap) begin
      if (dir == DIR_CW)
        next_val = (cur + s) % m;
      else if (dir == DIR_CCW)
        next_val = (cur + m - s) % m;
    end else begin
      if (dir == DIR_CW)
        next_val = (max_val - cur < step) ? max_val : cur + step;
      else if (dir == DIR_CCW)
        next_val = (cur < step) ? 0 : cur - step;
    end
  endfunction

endpackage

// File: rtl/qenc_if.sv
// Encoder bank bus: phase inputs and clears in, counters and ticks out.
// Ports: s1, s2, clr [CH]; value [CH*CNT_W]; r_tick, l_tick [CH].
interface qenc_if #(
  parameter int CH    = 2,
  parameter int CNT_W = 4
);
  logic [CH-1:0]       s1;
  logic [CH-1:0]       s2;
  logic [CH-1:0]       clr;
  logic [CH*CNT_W-1:0] value;
  logic [CH-1:0]       r_tick;
  logic [CH-1:0]       l_tick;

  modport master (
    output s1, s2, clr,
    input  value, r_tick, l_tick
  );

  modport slave (
    input  s1, s2, clr,
    output value, r_tick, l_tick
  );
endinterface

// File: rtl/qenc_debounce.sv
// One-bit 2-FF synchroniser followed by a stable-count filter.
// Ports: clk, rst (sync, active-low), din (async), dout (debounced).
module qenc_debounce
  import qenc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter bit RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      cnt  <= '0;
      dout <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_encoder_bank.sv
// CH-channel quadrature encoder front end: debounce, detent decode,
// wrap/saturate position counters, per-channel clear, direction ticks.
// Ports: clk, rst (sync, active-low), bus (qenc_if.slave).
// Latency: an s1 fall sampled at clk edge 0 shows r_tick/l_tick and the
// updated value right after edge DEB_CYCLES+2 (2 sync + DEB_CYCLES-1
// filter + 1 decode register). Optional macro QENC_ACCEL_EN enables
// per-channel acceleration (step ACCEL_STEP inside ACCEL_WIN cycles).
module quad_encoder_bank
  import qenc_pkg::*;
#(
  parameter int CH         = 2,
  parameter int CNT_W      = 4,
  parameter int MAX_VAL    = 7,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int WRAP       = 1
) (
  input  logic    clk,
  input  logic    rst,
  qenc_if.slave   bus
);

  logic [CH*CNT_W-1:0] value_w;
  logic [CH-1:0]       r_w;
  logic [CH-1:0]       l_w;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             s1_d;
    logic             s2_d;
    logic             s1_q;
    dir_e             dir;
    int unsigned      step;
    logic [CNT_W-1:0] val;
    logic [CNT_W-1:0] nxt;
    logic             r_q;
    logic             l_q;

    qenc_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (1'b1)
    ) u_deb_s1 (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.s1[i]),
      .dout (s1_d)
    );

    qenc_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (1'b1)
    ) u_deb_s2 (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.s2[i]),
      .dout (s2_d)
    );

    // Detent = debounced s1 falling; s2 level picks the direction.
    always_comb begin
      dir = DIR_NONE;
      if (s1_q && !s1_d)
        dir = s2_d ? DIR_CW : DIR_CCW;
    end

`ifdef QENC_ACCEL_EN
    localparam int ACCEL_WIN  = ACCEL_WIN_DEF;
    localparam int ACCEL_STEP = ACCEL_STEP_DEF;
    localparam int GW = $clog2(ACCEL_WIN + 1);

    logic [GW-1:0] gap;

    // Starts saturated so the first detent after reset is a single step.
    always_ff @(posedge clk) begin
      if (!rst)
        gap <= GW'(ACCEL_WIN);
      else if (dir != DIR_NONE)
        gap <= '0;
      else if (gap != GW'(ACCEL_WIN))
        gap <= gap + GW'(1);
    end

    assign step = (gap < GW'(ACCEL_WIN)) ? ACCEL_STEP : 1;
`else
    assign step = 1;
`endif

    assign nxt = CNT_W'(next_val(32'(val), dir, step,
                                 MAX_VAL, WRAP != 0));

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_q <= 1'b1;
        val  <= '0;
        r_q  <= 1'b0;
        l_q  <= 1'b0;
      end else begin
        s1_q <= s1_d;
        r_q  <= (dir == DIR_CW);
        l_q  <= (dir == DIR_CCW);
        if (bus.clr[i])
          val <= '0;
        else if (dir != DIR_NONE)
          val <= nxt;
      end
    end

    assign value_w[i*CNT_W +: CNT_W] = val;
    assign r_w[i] = r_q;
    assign l_w[i] = l_q;
  end

  assign bus.value  = value_w;
  assign bus.r_tick = r_w;
  assign bus.l_tick = l_w;

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: one wrapping and one saturating instance
// share stimulus and are checked against a detent-level model.
module tb_quad_encoder_bank;

  localparam int CH      = 2;
  localparam int CNT_W   = 4;
  localparam int MAX_VAL = 7;
  localparam int DEB     = 4;
  localparam int LAT     = DEB + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0] s1, s2, clr;

  qenc_if #(.CH(CH), .CNT_W(CNT_W)) bus_a ();
  qenc_if #(.CH(CH), .CNT_W(CNT_W)) bus_b ();

  assign bus_a.s1  = s1;
  assign bus_a.s2  = s2;
  assign bus_a.clr = clr;
  assign bus_b.s1  = s1;
  assign bus_b.s2  = s2;
  assign bus_b.clr = clr;

  quad_encoder_bank #(
    .CH(CH), .CNT_W(CNT_W), .MAX_VAL(MAX_VAL),
    .DEB_CYCLES(DEB), .WRAP(1)
  ) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  quad_encoder_bank #(
    .CH(CH), .CNT_W(CNT_W), .MAX_VAL(MAX_VAL),
    .DEB_CYCLES(DEB), .WRAP(0)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int vectors = 0;
  int errors  = 0;

  int exp_a [CH];
  int exp_b [CH];
  bit seen  [CH];

  int rcnt_a [CH], lcnt_a [CH], rpos_a [CH], lpos_a [CH];
  int rcnt_b [CH], lcnt_b [CH], rpos_b [CH], lpos_b [CH];
  int vt_a [CH], vt_b [CH];
  int both_hi;

  // Model: a detent moves the count by one step (two when accelerating,
  // all bench detents being far closer than 50 ms apart).
  function automatic int model_step(input int c);
`ifdef QENC_ACCEL_EN
    return seen[c] ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic int wrap_next(input int cur, input bit up,
                                   input int st);
    int m;
    m = MAX_VAL + 1;
    if (up) return (cur + st) % m;
    return ((cur - st) % m + m) % m;
  endfunction

  function automatic int sat_next(input int cur, input bit up,
                                  input int st);
    if (up) return (cur + st > MAX_VAL) ? MAX_VAL : cur + st;
    return (cur - st < 0) ? 0 : cur - st;
  endfunction

  function automatic int va(input int c);
    return int'(bus_a.value[c*CNT_W +: CNT_W]);
  endfunction

  function automatic int vb(input int c);
    return int'(bus_b.value[c*CNT_W +: CNT_W]);
  endfunction

  task automatic clear_obs();
    for (int c = 0; c < CH; c++) begin
      rcnt_a[c] = 0; lcnt_a[c] = 0; rpos_a[c] = -9; lpos_a[c] = -9;
      rcnt_b[c] = 0; lcnt_b[c] = 0; rpos_b[c] = -9; lpos_b[c] = -9;
      vt_a[c] = -1; vt_b[c] = -1;
    end
    both_hi = 0;
  endtask

  task automatic sample(input int k);
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (bus_a.r_tick[c]) begin rcnt_a[c]++; rpos_a[c] = k; end
      if (bus_a.l_tick[c]) begin lcnt_a[c]++; lpos_a[c] = k; end
      if (bus_b.r_tick[c]) begin rcnt_b[c]++; rpos_b[c] = k; end
      if (bus_b.l_tick[c]) begin lcnt_b[c]++; lpos_b[c] = k; end
      if ((bus_a.r_tick[c] && bus_a.l_tick[c]) ||
          (bus_b.r_tick[c] && bus_b.l_tick[c]))
        both_hi++;
      if (k == LAT) begin
        vt_a[c] = va(c);
        vt_b[c] = vb(c);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s1  = '1;
    s2  = '1;
    clr = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      exp_a[c] = 0;
      exp_b[c] = 0;
      seen[c]  = 1'b0;
    end
  endtask

  // One detent on every channel in mask; clrm pulses clr in the
  // very cycle the counter would update.
  task automatic do_detent(input string name, input logic [CH-1:0] mask,
                           input logic [CH-1:0] cw,
                           input logic [CH-1:0] clrm);
    int er, el, st, p;
    clear_obs();
    for (int c = 0; c < CH; c++)
      if (mask[c]) s2[c] = cw[c];
    repeat (DEB + 6) sample(-1);
    s1 = s1 & ~mask;
    for (int k = 0; k < DEB + 6; k++) begin
      sample(k);
      if (k == LAT - 1) clr = clrm;
      if (k == LAT) clr = '0;
    end
    s1 = '1;
    repeat (DEB + 6) sample(-1);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        st = model_step(c);
        exp_a[c] = wrap_next(exp_a[c], cw[c], st);
        exp_b[c] = sat_next(exp_b[c], cw[c], st);
        seen[c] = 1'b1;
      end
      if (clrm[c]) begin
        exp_a[c] = 0;
        exp_b[c] = 0;
      end
    end
    for (int c = 0; c < CH; c++) begin
      er = (mask[c] && cw[c]) ? 1 : 0;
      el = (mask[c] && !cw[c]) ? 1 : 0;
      vectors++;
      if (rcnt_a[c] !== er || lcnt_a[c] !== el ||
          rcnt_b[c] !== er || lcnt_b[c] !== el) begin
        errors++;
        $display("FAIL %s ch%0d ticks r=%0d/%0d l=%0d/%0d want r=%0d l=%0d",
                 name, c, rcnt_a[c], rcnt_b[c], lcnt_a[c], lcnt_b[c],
                 er, el);
      end
      if (mask[c]) begin
        p = cw[c] ? rpos_a[c] : lpos_a[c];
        vectors++;
        if (p !== LAT) begin
          errors++;
          $display("FAIL %s ch%0d latency got %0d want %0d",
                   name, c, p, LAT);
        end
        vectors++;
        if (vt_a[c] !== exp_a[c] || vt_b[c] !== exp_b[c]) begin
          errors++;
          $display("FAIL %s ch%0d value_at_tick got %0d/%0d want %0d/%0d",
                   name, c, vt_a[c], vt_b[c], exp_a[c], exp_b[c]);
        end
      end
      vectors++;
      if (va(c) !== exp_a[c]) begin
        errors++;
        $display("FAIL %s ch%0d wrap_value got %0d want %0d",
                 name, c, va(c), exp_a[c]);
      end
      vectors++;
      if (vb(c) !== exp_b[c]) begin
        errors++;
        $display("FAIL %s ch%0d sat_value got %0d want %0d",
                 name, c, vb(c), exp_b[c]);
      end
    end
    vectors++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL %s r_and_l_together got %0d want 0", name, both_hi);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s1  = '1;
    s2  = '1;
    clr = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus_a.value !== '0 || bus_b.value !== '0 ||
        bus_a.r_tick !== '0 || bus_a.l_tick !== '0 ||
        bus_b.r_tick !== '0 || bus_b.l_tick !== '0) begin
      errors++;
      $display("FAIL reset_state got %h/%h want 0/0",
               bus_a.value, bus_b.value);
    end
    do_reset();
    rst = 1'b1;
    clear_obs();
    repeat (100) sample(-1);
    vectors++;
    if (rcnt_a[0] + rcnt_a[1] + lcnt_a[0] + lcnt_a[1] +
        rcnt_b[0] + rcnt_b[1] + lcnt_b[0] + lcnt_b[1] != 0 ||
        bus_a.value !== '0 || bus_b.value !== '0) begin
      errors++;
      $display("FAIL idle_after_reset ticks=%0d value=%h want 0",
               rcnt_a[0] + lcnt_a[0], bus_a.value);
    end
  endtask

  task automatic test_cw();
    do_detent("cw_ch0", 2'b01, 2'b01, 2'b00);
    vectors++;
    if (va(0) !== 1 || va(1) !== 0) begin
      errors++;
      $display("FAIL cw_ch0_direct got %0d,%0d want 1,0", va(0), va(1));
    end
  endtask

  task automatic test_wrap();
    clr = 2'b01;
    sample(-1);
    clr = '0;
    exp_a[0] = 0;
    exp_b[0] = 0;
    vectors++;
    if (va(0) !== 0 || vb(0) !== 0) begin
      errors++;
      $display("FAIL clr_ch0 got %0d/%0d want 0/0", va(0), vb(0));
    end
    do_detent("ccw_wrap", 2'b01, 2'b00, 2'b00);
  endtask

  task automatic test_saturate();
    repeat (MAX_VAL + 1) do_detent("cw_sat", 2'b01, 2'b01, 2'b00);
  endtask

  task automatic test_glitch();
    int len;
    len = $urandom_range(1, DEB - 1);
    clear_obs();
    s1[1] = 1'b0;
    repeat (len) sample(-1);
    s1[1] = 1'b1;
    repeat (DEB + 6) sample(-1);
    vectors++;
    if (rcnt_a[1] + lcnt_a[1] + rcnt_b[1] + lcnt_b[1] != 0 ||
        va(1) !== exp_a[1] || vb(1) !== exp_b[1]) begin
      errors++;
      $display("FAIL glitch_len%0d ticks=%0d value=%0d want 0,%0d",
               len, rcnt_a[1] + lcnt_a[1], va(1), exp_a[1]);
    end
  endtask

  task automatic test_min_pulse();
    int st;
    s2[1] = 1'b1;
    repeat (DEB + 6) sample(-1);
    clear_obs();
    s1[1] = 1'b0;
    for (int k = 0; k < DEB; k++) sample(k);
    s1[1] = 1'b1;
    for (int k = DEB; k < DEB + 10; k++) sample(k);
    st = model_step(1);
    exp_a[1] = wrap_next(exp_a[1], 1'b1, st);
    exp_b[1] = sat_next(exp_b[1], 1'b1, st);
    seen[1] = 1'b1;
    vectors++;
    if (rcnt_a[1] !== 1 || rpos_a[1] !== LAT || lcnt_a[1] !== 0) begin
      errors++;
      $display("FAIL min_pulse r=%0d at %0d want 1 at %0d",
               rcnt_a[1], rpos_a[1], LAT);
    end
    vectors++;
    if (va(1) !== exp_a[1] || vb(1) !== exp_b[1]) begin
      errors++;
      $display("FAIL min_pulse_value got %0d/%0d want %0d/%0d",
               va(1), vb(1), exp_a[1], exp_b[1]);
    end
  endtask

  task automatic test_clr_collision();
    do_detent("pre_clr", 2'b01, 2'b01, 2'b00);
    do_detent("clr_hit", 2'b01, 2'b01, 2'b01);
  endtask

  task automatic test_simultaneous();
    do_detent("both_ch", 2'b11, 2'b01, 2'b00);
    do_detent("both_ch_rev", 2'b11, 2'b10, 2'b00);
  endtask

  task automatic test_reset_mid();
    do_detent("pre_rst", 2'b01, 2'b01, 2'b00);
    s1[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    vectors++;
    if (bus_a.value !== '0 || bus_b.value !== '0 ||
        bus_a.r_tick !== '0 || bus_a.l_tick !== '0) begin
      errors++;
      $display("FAIL reset_mid_state got %h/%h want 0/0",
               bus_a.value, bus_b.value);
    end
    rst = 1'b1;
    clear_obs();
    repeat (DEB + 20) sample(-1);
    vectors++;
    if (rcnt_a[0] + lcnt_a[0] + rcnt_b[0] + lcnt_b[0] != 0 ||
        bus_a.value !== '0) begin
      errors++;
      $display("FAIL reset_mid_release ticks=%0d value=%h want 0,0",
               rcnt_a[0] + lcnt_a[0], bus_a.value);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] mask, cw, clrm;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) test_glitch();
      mask = CH'($urandom_range(1, 3));
      cw   = CH'($urandom);
      clrm = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      do_detent("random", mask, cw, clrm);
    end
  endtask

`ifdef QENC_ACCEL_EN
  task automatic test_accel();
    do_reset();
    rst = 1'b1;
    sample(-1);
    do_detent("accel_1", 2'b01, 2'b01, 2'b00);
    vectors++;
    if (va(0) !== 1) begin
      errors++;
      $display("FAIL accel_first got %0d want 1", va(0));
    end
    do_detent("accel_2", 2'b01, 2'b01, 2'b00);
    vectors++;
    if (va(0) !== 3) begin
      errors++;
      $display("FAIL accel_second got %0d want 3", va(0));
    end
  endtask
`endif

  initial begin
    s1  = '1;
    s2  = '1;
    clr = '0;
    test_reset();
    test_cw();
    test_wrap();
    test_saturate();
    test_glitch();
    test_min_pulse();
    test_clr_collision();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef QENC_ACCEL_EN
    test_accel();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_bank.md
Name: quad_encoder_bank

Overview:
- Parametrised successor to the single EC11 rotary-encoder front end.
- Decodes CH independent quadrature encoders (s1/s2 pairs), each with input synchronisation and debounce.
- Each channel keeps a CNT_W-bit position counter with selectable wrap or saturate range, per-channel clear, and one-cycle direction ticks.
- Feeds page/menu selection and settings adjustment in the display top level; r_tick/l_tick keep the existing semantics.

Parameters:
- CH, 2, number of encoder channels (1..8).
- CNT_W, 4, width of each position counter.
- MAX_VAL, 7, counter upper limit (must be below 2^CNT_W); lower limit is 0.
- DEB_CYCLES, 50000, consecutive stable cycles required before a debounced level changes (1 ms at 50 MHz).
- WRAP, 1, 1 = wrap MAX_VAL<->0; 0 = saturate at 0 and MAX_VAL.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-low reset.
- s1  in  CH  encoder A phase per channel; asynchronous, idle high.
- s2  in  CH  encoder B phase per channel; asynchronous, idle high.
- clr  in  CH  per-channel synchronous clear of the counter to 0.
- value  out  CH*CNT_W  packed counters; channel i occupies [i*CNT_W +: CNT_W].
- r_tick  out  CH  one-cycle pulse per clockwise detent.
- l_tick  out  CH  one-cycle pulse per counter-clockwise detent.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst sampled low at a clk edge).
  - value = 0; r_tick = l_tick = 0.
  - Synchroniser flops and debounced levels = 1 (idle high), debounce counters = 0.
  - No tick may be generated by the release of reset.
- Synchronisation: 2-FF synchroniser on every s1/s2 bit.
- Debounce, per input:
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments.
  - On reaching DEB_CYCLES-1, the debounced level takes the synchronised level and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles is ignored.
- Direction decode, per channel, on a debounced-s1 falling edge (1->0):
  - Debounced s2 = 1: clockwise. Assert r_tick for one cycle; counter +1.
  - Debounced s2 = 0: counter-clockwise. Assert l_tick for one cycle; counter -1.
  - Debounced-s1 rising edges and s2 edges produce no action.
- Latency: a clean s1 fall at cycle 0 gives the tick and the updated value at cycle 2 + DEB_CYCLES + 1, ±1 cycle.
  - The bench checks against exact RTL latency, documented in the header.
- Arithmetic boundaries, at CNT_W bits:
  - WRAP=1: MAX_VAL +1 -> 0; 0 -1 -> MAX_VAL.
  - WRAP=0: the counter holds at MAX_VAL or 0, but the tick still pulses.
- Simultaneous events:
  - clr and a detent in the same cycle: clr wins (value = 0) and the tick still pulses.
  - Channels are fully independent; simultaneous detents on different channels are all honoured.
- Reset mid-debounce or mid-rotation: all state returns to reset values; any partial debounce is discarded.
- r_tick and l_tick are never both high on the same channel.

Optional Feature:
- Macro QENC_ACCEL_EN.
- Defined:
  - Each channel gets a gap counter that saturates at ACCEL_WIN. It resets to 0 on each detent.
  - If a detent arrives while the gap counter is below ACCEL_WIN (default 2_500_000 cycles, 50 ms), the step is ACCEL_STEP (default 2); otherwise the step is 1.
  - Wrap/saturate rules apply to the full step: wrap is modulo MAX_VAL+1; saturate clamps.
  - Ticks remain one pulse per detent.
  - ACCEL_WIN and ACCEL_STEP are localparams inside the `ifdef.
- Not defined: step is always 1; no gap counters are synthesised.

Decomposition:
- Package qenc_pkg:
  - Direction encoding constants (DIR_NONE, DIR_CW, DIR_CCW).
  - Default DEB_CYCLES.
  - ACCEL_WIN and ACCEL_STEP defaults.
  - Function for the wrap/saturate next-value.
- Sub-module qenc_debounce:
  - Contains the 2-FF synchroniser and the stable-count filter for one bit.
  - Parameters DEB_CYCLES, RST_VAL.
  - Instantiated 2*CH times in a generate loop.
- Decode and counter logic is a per-channel generate block in the top.

Test Plan (DEB_CYCLES = 4 for simulation; CH = 2, CNT_W = 4, MAX_VAL = 7, WRAP = 1):
- Reset then idle high for 100 cycles -> value = 0, no ticks.
- Ch0 clean CW detent (s1 falls while s2 = 1) -> exactly one r_tick[0] pulse; value[3:0] = 1; ch1 unchanged.
- Ch0 at 0, one CCW detent -> one l_tick[0]; value[3:0] = 7 (wrap).
- Rebuild with WRAP = 0, ch0 at 7, CW detent -> r_tick[0] pulses; value stays 7.
- 3-cycle glitch on s1[1] -> no tick, value unchanged; a 4-cycle stable low -> tick.
- Detent and clr[0] in the same cycle -> value[3:0] = 0 and the tick pulses.
- Assert rst mid-debounce -> all outputs 0, no tick after reset releases.
- With QENC_ACCEL_EN: two CW detents 10 cycles apart -> 0 -> 1 -> 3.
